cp0_int_ctrl: RTL and testbench

//   Coprocessor-0 exception/interrupt controller of the P7 MIPS pipeline; directly consumes the IRQ lines of the timer and bus devices.

---
 rtl/cp0_int_ctrl.sv | 130 +++++++++++++
 tb/tb_cp0_int_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cp0_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cp0_int_ctrl
// Description : Coprocessor-0 exception/interrupt controller. Holds SR, Cause,
//               EPC and PrID, serves mfc0/mtc0 and decides each cycle whether
//               the M-stage instruction is interrupted.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_int_ctrl #(
    parameter logic [31:0] PRID = 32'h0000_2020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] Din,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] Dout
);

    localparam logic [4:0] c_REG_SR    = 5'd12;
    localparam logic [4:0] c_REG_CAUSE = 5'd13;
    localparam logic [4:0] c_REG_EPC   = 5'd14;
    localparam logic [4:0] c_REG_PRID  = 5'd15;

    // Architectural state
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;

    logic        w_hw_req;
    logic        w_exc_req;
    logic        w_int_req;
    logic [31:0] w_pc_aligned;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    // PC[1:0] is never meaningful for a word-aligned victim address.
    wire w_unused = &{1'b0, PC[1:0]};

    // Hardware requests look at live HWInt so an IRQ is taken the cycle it rises.
    assign w_hw_req     = ie_q & ~exl_q & (|(HWInt & im_q));
    assign w_exc_req    = ~exl_q & (ExcCodeIn != 5'd0);
    assign w_int_req    = (w_hw_req | w_exc_req) & ~reset;
    assign IntReq       = w_int_req;
    assign EPC          = epc_q;
    assign w_pc_aligned = {PC[31:2], 2'b00};

    assign w_sr    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign w_cause = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b00};

    // mfc0 read mux: reflects registered state only, so a same-cycle mtc0 is not visible.
    always_comb begin
        Dout = 32'h0;
        case (A1)
            c_REG_SR:    Dout = w_sr;
            c_REG_CAUSE: Dout = w_cause;
            c_REG_EPC:   Dout = epc_q;
            c_REG_PRID:  Dout = PRID;
            default:     Dout = 32'h0;
        endcase
    end

    // Next-state: exception entry wins over eret and over any concurrent mtc0.
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ip_d      = HWInt;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (w_int_req) begin
            exl_d     = 1'b1;
            bd_d      = BD;
            exccode_d = w_hw_req ? 5'd0 : ExcCodeIn;
            epc_d     = BD ? (w_pc_aligned - 32'd4) : w_pc_aligned;
        end else begin
            if (EXLClr) begin
                exl_d = 1'b0;
            end
            // An SR write in the same cycle as eret overrides the cleared EXL bit.
            if (WE) begin
                case (A2)
                    c_REG_SR: begin
                        im_d  = Din[15:10];
                        exl_d = Din[1];
                        ie_d  = Din[0];
                    end
                    c_REG_EPC: epc_d = {Din[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_int_ctrl
// Description : Directed self-checking bench for cp0_int_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_int_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] Din;
    logic        WE;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] Dout;

    int checks_q;
    int failures_q;

    cp0_int_ctrl #(.PRID(32'h0000_2020)) dut (
        .clk       (clk),
        .reset     (reset),
        .A1        (A1),
        .A2        (A2),
        .Din       (Din),
        .WE        (WE),
        .PC        (PC),
        .BD        (BD),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .IntReq    (IntReq),
        .EPC       (EPC),
        .Dout      (Dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_q++;
        if (obs !== exp) begin
            failures_q++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read a CP0 register through the mfc0 port.
    task automatic rd(input logic [4:0] r, input string tag, input logic [31:0] exp);
        A1 = r;
        #1;
        check_eq(tag, Dout, exp);
    endtask

    initial begin
        checks_q   = 0;
        failures_q = 0;
        reset = 1'b1; A1 = 5'd0; A2 = 5'd0; Din = 32'h0; WE = 1'b0;
        PC = 32'h0; BD = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;

        // Reset state
        check_eq("rst_intreq", {31'b0, IntReq}, 32'h0);
        rd(5'd12, "rst_sr",    32'h0);
        rd(5'd13, "rst_cause", 32'h0);
        rd(5'd14, "rst_epc",   32'h0);
        rd(5'd15, "prid",      32'h0000_2020);

        // 1) Timer IRQ with IM[10], IE enabled
        WE = 1'b1; A2 = 5'd12; Din = 32'h0000_0401;
        step();
        WE = 1'b0;
        HWInt = 6'b000001; PC = 32'h0000_3010; BD = 1'b0;
        #1;
        check_eq("t1_intreq", {31'b0, IntReq}, 32'h1);
        step();
        rd(5'd13, "t1_cause", 32'h0000_0400);
        HWInt = 6'd0;
        rd(5'd12, "t1_sr", 32'h0000_0403);
        check_eq("t1_epc", EPC, 32'h0000_3010);
        check_eq("t1_masked", {31'b0, IntReq}, 32'h0);

        // 2) eret with concurrent SR write, then exception in a delay slot
        EXLClr = 1'b1; WE = 1'b1; A2 = 5'd12; Din = 32'h0000_0801;
        step();
        EXLClr = 1'b0; WE = 1'b0;
        rd(5'd12, "t2_sr", 32'h0000_0801);
        BD = 1'b1; PC = 32'h0000_3024; ExcCodeIn = 5'd4;
        #1;
        check_eq("t2_intreq", {31'b0, IntReq}, 32'h1);
        step();
        ExcCodeIn = 5'd0; BD = 1'b0;
        rd(5'd13, "t2_cause", 32'h8000_0010);
        check_eq("t2_epc", EPC, 32'h0000_3020);

        // 3) IRQ and exception together: interrupt wins, ExcCode = 0
        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0;
        rd(5'd12, "t3_sr", 32'h0000_0801);
        HWInt = 6'b000010; ExcCodeIn = 5'd10; PC = 32'h0000_3030;
        step();
        HWInt = 6'd0; ExcCodeIn = 5'd0;
        rd(5'd13, "t3_cause", 32'h0000_0800);
        check_eq("t3_epc", EPC, 32'h0000_3030);

        // 4) EXL masks everything; eret re-exposes pending IRQ
        HWInt = 6'b000011; ExcCodeIn = 5'd12; PC = 32'h0000_3038;
        #1;
        check_eq("t4_masked", {31'b0, IntReq}, 32'h0);
        step();
        check_eq("t4_epc_hold", EPC, 32'h0000_3030);
        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0; ExcCodeIn = 5'd0;
        check_eq("t4_reenter", {31'b0, IntReq}, 32'h1);

        // 5) mtc0 EPC coincident with entry is discarded
        WE = 1'b1; A2 = 5'd14; Din = 32'h0000_3007; PC = 32'h0000_3040;
        step();
        WE = 1'b0; HWInt = 6'd0;
        check_eq("t5_epc_victim", EPC, 32'h0000_3040);
        rd(5'd13, "t5_cause", 32'h0000_0C00);
        WE = 1'b1; A2 = 5'd14; Din = 32'h0000_3007;
        step();
        WE = 1'b0;
        check_eq("t5_epc_write", EPC, 32'h0000_3004);
        WE = 1'b1; A2 = 5'd13; Din = 32'hFFFF_FFFF;
        step();
        WE = 1'b0;
        rd(5'd13, "t5_cause_ro", 32'h0000_0000);

        // 6) Read-side behaviour and reset mid-handler
        rd(5'd7, "t6_unmapped", 32'h0);
        WE = 1'b1; A2 = 5'd12; Din = 32'h0;
        rd(5'd12, "t6_no_bypass", 32'h0000_0803);
        WE = 1'b0;
        HWInt = 6'b000100;
        rd(5'd13, "t6_ip_lag0", 32'h0);
        step();
        rd(5'd13, "t6_ip_lag1", 32'h0000_1000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd(5'd12, "t6_rst_sr",    32'h0);
        rd(5'd14, "t6_rst_epc",   32'h0);
        rd(5'd13, "t6_rst_cause", 32'h0);
        check_eq("t6_rst_intreq", {31'b0, IntReq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
        $finish;
    end

endmodule
`default_nettype wire
